// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// State encoding and grant-index width calculation.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  function automatic int grant_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled in one interface.
// master = arbiter view, slave = requesters/memory core view.
interface mem_bus_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GRANT_W = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_write;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic                          mem_resp_valid;
  logic [DATA_WIDTH-1:0]         mem_resp_rdata;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;
  logic                          err_spurious;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_write, mem_addr, mem_wdata,
    output grant_id, busy, err_spurious
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_write, mem_addr, mem_wdata,
    input  grant_id, busy, err_spurious
  );

endinterface

// File: rtl/mem_arb_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// Rotates the request vector, priority-encodes the lowest bit, then un-rotates.
module mem_arb_rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               any,
  output logic [GRANT_W-1:0] grant
);

  logic [NUM_REQ-1:0] rotated_s;
  logic [GRANT_W-1:0] offset_s;
  logic [GRANT_W:0]   sum_s;

  // rr_ptr lands on bit 0 after the rotate
  assign rotated_s = NUM_REQ'({req, req} >> rr_ptr);
  assign any       = |req;

  // Lowest set bit of the rotated vector wins
  always_comb begin
    offset_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      offset_s = rotated_s[i] ? GRANT_W'(i) : offset_s;
    end
  end

  assign sum_s = {1'b0, offset_s} + {1'b0, rr_ptr};
  assign grant = (sum_s >= (GRANT_W + 1)'(NUM_REQ)) ?
                 GRANT_W'(sum_s - (GRANT_W + 1)'(NUM_REQ)) : sum_s[GRANT_W-1:0];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory-core port among NUM_REQ requesters, one transaction at a time,
// with round-robin selection and responses routed back to the issuing requester.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  localparam int GRANT_W = grant_w(NUM_REQ);

  arb_state_e              state_r, next_state_s;
  logic [GRANT_W-1:0]      rr_ptr_r, grant_r, pick_s, rr_next_s;
  logic                    pick_any_s, accept_s, complete_s;
  logic [NUM_REQ-1:0]      pick_onehot_s, owner_onehot_s, req_ready_s, resp_valid_r;
  logic                    sel_write_s, mem_write_r, mem_req_valid_s, busy_s, err_r;
  logic [ADDR_WIDTH-1:0]   sel_addr_s, mem_addr_r;
  logic [DATA_WIDTH-1:0]   sel_wdata_s, mem_wdata_r, resp_rdata_r;

  mem_arb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_r),
    .any    (pick_any_s),
    .grant  (pick_s)
  );

  assign accept_s   = (state_r == ARB_IDLE) && pick_any_s;
  assign complete_s = (state_r == ARB_WAIT) && bus.mem_resp_valid;
  assign rr_next_s  = (grant_r == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_r + GRANT_W'(1);

  // Decode picked/owner indices and mux the picked requester's fields
  always_comb begin
    pick_onehot_s  = '0;
    owner_onehot_s = '0;
    sel_write_s    = 1'b0;
    sel_addr_s     = '0;
    sel_wdata_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot_s[i]  = (pick_s == GRANT_W'(i));
      owner_onehot_s[i] = (grant_r == GRANT_W'(i));
      sel_write_s = pick_onehot_s[i] ? bus.req_write[i] : sel_write_s;
      sel_addr_s  = pick_onehot_s[i] ? bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
      sel_wdata_s = pick_onehot_s[i] ? bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : sel_wdata_s;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_IDLE:  next_state_s = pick_any_s ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: next_state_s = bus.mem_req_ready ? ARB_WAIT : ARB_ISSUE;
      ARB_WAIT:  next_state_s = bus.mem_resp_valid ? ARB_IDLE : ARB_WAIT;
      default:   next_state_s = ARB_IDLE;
    endcase
  end

  // State-decoded outputs; the accept pulse only exists while IDLE
  always_comb begin
    req_ready_s     = '0;
    mem_req_valid_s = 1'b0;
    busy_s          = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        req_ready_s = pick_any_s ? pick_onehot_s : '0;
      end
      ARB_ISSUE: begin
        mem_req_valid_s = 1'b1;
        busy_s          = 1'b1;
      end
      ARB_WAIT: begin
        busy_s = 1'b1;
      end
      default: begin
        req_ready_s     = '0;
        mem_req_valid_s = 1'b0;
        busy_s          = 1'b0;
      end
    endcase
  end

  // Request latches, response register, round-robin pointer and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      resp_valid_r <= '0;
      resp_rdata_r <= '0;
      err_r        <= 1'b0;
    end else begin
      resp_valid_r <= '0;
      if (accept_s) begin
        grant_r     <= pick_s;
        mem_write_r <= sel_write_s;
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
      end
      if (complete_s) begin
        resp_valid_r <= owner_onehot_s;
        resp_rdata_r <= bus.mem_resp_rdata;
        rr_ptr_r     <= rr_next_s;
      end
      // A completion outside WAIT has no owner; it is dropped and flagged
      if (bus.mem_resp_valid && (state_r != ARB_WAIT)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_rdata    = resp_rdata_r;
  assign bus.mem_req_valid = mem_req_valid_s;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.grant_id      = grant_r;
  assign bus.busy          = busy_s;
  assign bus.err_spurious  = err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares on accept, memory handshake and response.
module tb_mem_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          owner;
  } mem_exp_t;

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    bit          chk_data;
  } resp_exp_t;

  logic clock = 1'b0;
  logic reset;

  mem_exp_t    exp_mem_q[$];
  resp_exp_t   exp_resp_q[$];
  int          exp_acc_q[$];
  logic [31:0] rdata_q[$];

  int checks = 0;
  int errors = 0;
  bit resp_block = 1'b0;
  bit spur = 1'b0;
  int ready_wait = 0;
  int phase = 0;
  int wcnt = 0;
  int stall;
  mem_exp_t  mon_me;
  resp_exp_t mon_re;
  int        mon_ao;

  always #5 clock = ~clock;

  mem_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int o);
    logic [1:0] v;
    v = 2'b01;
    return v << o;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},     64'(bus.req_ready), 64'd0);
    check({tag, "_resp_valid"},    64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_rdata"},    64'(bus.resp_rdata), 64'd0);
    check({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, "_mem_write"},     64'(bus.mem_write), 64'd0);
    check({tag, "_mem_addr"},      64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"},     64'(bus.mem_wdata), 64'd0);
    check({tag, "_grant_id"},      64'(bus.grant_id), 64'd0);
    check({tag, "_busy"},          64'(bus.busy), 64'd0);
    check({tag, "_err_spurious"},  64'(bus.err_spurious), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      if (|bus.req_ready) begin
        if (exp_acc_q.size() == 0) begin
          check("unexpected_accept", 64'(bus.req_ready), 64'd0);
        end else begin
          mon_ao = exp_acc_q.pop_front();
          check("req_ready_onehot", 64'(bus.req_ready), 64'(onehot(mon_ao)));
        end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_mem_q.size() == 0) begin
          check("unexpected_mem_req", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_me = exp_mem_q.pop_front();
          check("mem_write", 64'(bus.mem_write), 64'(mon_me.write));
          check("mem_addr",  64'(bus.mem_addr),  64'(mon_me.addr));
          check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_me.wdata));
          check("grant_id",  64'(bus.grant_id),  64'(mon_me.owner));
        end
      end
      if (|bus.resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_resp", 64'(bus.resp_valid), 64'd0);
        end else begin
          mon_re = exp_resp_q.pop_front();
          check("resp_valid_owner", 64'(bus.resp_valid), 64'(onehot(mon_re.owner)));
          if (mon_re.chk_data) begin
            check("resp_rdata", 64'(bus.resp_rdata), 64'(mon_re.rdata));
          end
        end
      end
    end
  end

  // Memory-core responder: optional accept stall, completion one cycle after accept
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = spur;
      if (!reset) begin
        phase = 0;
        wcnt  = 0;
      end else if (phase == 0) begin
        if (bus.mem_req_valid) begin
          if (wcnt < ready_wait) begin
            wcnt++;
          end else begin
            bus.mem_req_ready = 1'b1;
            phase = 1;
            wcnt  = 0;
          end
        end
      end else if (!resp_block) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
        phase = 0;
      end
    end
  end

  task automatic drive_req(input logic [1:0] valid, input logic [1:0] wr,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int n_acc, input string name);
    int acc;
    int n;
    acc = 0;
    n   = 0;
    @(posedge clock);
    #1;
    bus.req_valid = valid;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (acc < n_acc && n < 100) begin
      @(negedge clock);
      n++;
      if (|bus.req_ready) acc++;
    end
    if (acc < n_acc) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got %0d accepts want %0d", name, acc, n_acc);
    end
    @(posedge clock);
    #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while ((bus.busy || exp_acc_q.size() != 0 || exp_mem_q.size() != 0 ||
            exp_resp_q.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: busy %0b pending %0d want idle and 0", name, bus.busy,
               exp_acc_q.size() + exp_mem_q.size() + exp_resp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single read from requester 0, latency to resp_valid at c3
    exp_acc_q.push_back(0);
    exp_mem_q.push_back(mem_exp_t'{1'b0, 32'h10, 32'h0, 0});
    rdata_q.push_back(32'hCAFE);
    exp_resp_q.push_back(resp_exp_t'{0, 32'hCAFE, 1'b1});
    @(posedge clock);
    #1;
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0, 32'h10};
    bus.req_wdata = '0;
    @(posedge clock);
    #1;
    bus.req_valid = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("t1_resp_valid_c3", 64'(bus.resp_valid), 64'h1);
    check("t1_resp_rdata_c3", 64'(bus.resp_rdata), 64'hCAFE);
    wait_idle("t1");

    // Write from requester 1; rr_ptr now 1
    exp_acc_q.push_back(1);
    exp_mem_q.push_back(mem_exp_t'{1'b1, 32'h4, 32'h1234, 1});
    rdata_q.push_back(32'h5A5A);
    exp_resp_q.push_back(resp_exp_t'{1, 32'h0, 1'b0});
    drive_req(2'b10, 2'b10, {32'h4, 32'h0}, {32'h1234, 32'h0}, 1, "t4");
    wait_idle("t4");

    // Both requesting for four transactions: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      exp_acc_q.push_back(k % 2);
      exp_mem_q.push_back(mem_exp_t'{1'b0, (k % 2 == 1) ? 32'h200 : 32'h100,
                                     (k % 2 == 1) ? 32'hB : 32'hA, k % 2});
      rdata_q.push_back(32'h1111 * (k + 1));
      exp_resp_q.push_back(resp_exp_t'{k % 2, 32'h1111 * (k + 1), 1'b1});
    end
    drive_req(2'b11, 2'b00, {32'h200, 32'h100}, {32'hB, 32'hA}, 4, "t2");
    wait_idle("t2");

    // Memory stalls the request three cycles; fields must hold
    ready_wait = 3;
    stall      = 0;
    exp_acc_q.push_back(0);
    exp_mem_q.push_back(mem_exp_t'{1'b0, 32'h20, 32'h55, 0});
    rdata_q.push_back(32'h3C3C);
    exp_resp_q.push_back(resp_exp_t'{0, 32'h3C3C, 1'b1});
    @(posedge clock);
    #1;
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h20};
    bus.req_wdata = {32'h0, 32'h55};
    @(posedge clock);
    #1;
    bus.req_valid = '0;
    repeat (6) begin
      @(negedge clock);
      if (bus.mem_req_valid && !bus.mem_req_ready) begin
        stall++;
        check("t3_addr_stable",  64'(bus.mem_addr),  64'h20);
        check("t3_wdata_stable", 64'(bus.mem_wdata), 64'h55);
      end
    end
    check("t3_stall_cycles", 64'(stall), 64'd3);
    ready_wait = 0;
    wait_idle("t3");

    // Completion pulse while IDLE
    @(negedge clock);
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    @(negedge clock);
    check("t5_err_spurious", 64'(bus.err_spurious), 64'd1);
    check("t5_busy",         64'(bus.busy), 64'd0);
    @(negedge clock);
    check("t5_no_resp",      64'(bus.resp_valid), 64'd0);
    check("t5_err_sticky",   64'(bus.err_spurious), 64'd1);

    // Reset in WAIT drops the transaction
    resp_block = 1'b1;
    exp_acc_q.push_back(1);
    exp_mem_q.push_back(mem_exp_t'{1'b0, 32'h40, 32'h0, 1});
    drive_req(2'b10, 2'b00, {32'h40, 32'h0}, '0, 1, "t6");
    @(negedge clock);
    @(negedge clock);
    check("t6_busy_in_wait", 64'(bus.busy), 64'd1);
    check("t6_no_mem_req",   64'(bus.mem_req_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check_zero("t6_rst");
    @(negedge clock);
    resp_block = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    exp_acc_q.push_back(1);
    exp_mem_q.push_back(mem_exp_t'{1'b0, 32'h44, 32'h0, 1});
    rdata_q.push_back(32'h6666);
    exp_resp_q.push_back(resp_exp_t'{1, 32'h6666, 1'b1});
    drive_req(2'b10, 2'b00, {32'h44, 32'h0}, '0, 1, "t6b");
    wait_idle("t6b");

    // Pointer advanced past 1, so both requesting picks 0
    exp_acc_q.push_back(0);
    exp_mem_q.push_back(mem_exp_t'{1'b0, 32'h100, 32'hA, 0});
    rdata_q.push_back(32'h7777);
    exp_resp_q.push_back(resp_exp_t'{0, 32'h7777, 1'b1});
    drive_req(2'b11, 2'b00, {32'h200, 32'h100}, {32'hB, 32'hA}, 1, "t7");
    wait_idle("t7");

    repeat (3) @(negedge clock);
    check("queues_drained", 64'(exp_acc_q.size() + exp_mem_q.size() + exp_resp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
